// File: rtl/fan_speed_ctrl_if.sv
// rtl/fan_speed_ctrl_if.sv - front-panel buttons in, demux enable/select out
interface fan_speed_ctrl_if;
  logic btn_pwr;
  logic btn_up;
  logic btn_down;
  logic e;
  logic s1;
  logic s0;
  logic ramping;

  modport master (
    output btn_pwr, btn_up, btn_down,
    input  e, s1, s0, ramping
  );

  modport slave (
    input  btn_pwr, btn_up, btn_down,
    output e, s1, s0, ramping
  );
endinterface

// File: rtl/fan_speed_ctrl.sv
// rtl/fan_speed_ctrl.sv - debounced power/up/down buttons driving a soft-start fan select
module fan_speed_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RAMP_CYCLES     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  fan_speed_ctrl_if.slave  bus
);

  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RCW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] RAMP_LAST = RCW'(RAMP_CYCLES - 1);

  typedef enum logic {ST_OFF, ST_RUN} state_t;

  // Button index 0 = power, 1 = up, 2 = down.
  logic [2:0]     btn_raw;
  logic [2:0]     meta_q, meta_d;
  logic [2:0]     sync_q, sync_d;
  logic [2:0]     deb_q, deb_d;
  logic [2:0]     deb_prev_q, deb_prev_d;
  logic [2:0]     press_q, press_d;
  logic [DCW-1:0] cnt_q [3];
  logic [DCW-1:0] cnt_d [3];

  assign btn_raw = {bus.btn_down, bus.btn_up, bus.btn_pwr};

  always_comb begin
    meta_d     = btn_raw;
    sync_d     = meta_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    press_d    = deb_q & ~deb_prev_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= '0;
      sync_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Power wins; up and down together cancel each other.
  logic pwr_p, up_p, dn_p;
  assign pwr_p = press_q[0];
  assign up_p  = ~press_q[0] & press_q[1] & ~press_q[2];
  assign dn_p  = ~press_q[0] & ~press_q[1] & press_q[2];

  state_t         state_q, state_d;
  logic [1:0]     cur_q, cur_d;
  logic [1:0]     tgt_q, tgt_d;
  logic [RCW-1:0] tmr_q, tmr_d;
  logic           e_q, e_d;
  logic           ramping_q, ramping_d;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    tmr_d   = '0;
    if (up_p && tgt_q != 2'b11) tgt_d = tgt_q + 2'd1;
    if (dn_p && tgt_q != 2'b00) tgt_d = tgt_q - 2'd1;
    case (state_q)
      ST_OFF: begin
        cur_d = 2'b00;
        if (pwr_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pwr_p) begin
          state_d = ST_OFF;
          cur_d   = 2'b00;
        end else begin
          // Slow-down is immediate; speed-up only ever creeps one level per interval.
          if (cur_q > tgt_d) cur_d = tgt_d;
          if (cur_d < tgt_d) begin
            if (tmr_q == RAMP_LAST) begin
              cur_d = cur_d + 2'd1;
            end else begin
              tmr_d = tmr_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = ST_OFF;
        cur_d   = 2'b00;
      end
    endcase
    e_d       = (state_d == ST_RUN);
    ramping_d = (state_d == ST_RUN) && (cur_d < tgt_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      cur_q     <= 2'b00;
      tgt_q     <= 2'b01;
      tmr_q     <= '0;
      e_q       <= 1'b0;
      ramping_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      tmr_q     <= tmr_d;
      e_q       <= e_d;
      ramping_q <= ramping_d;
    end
  end

  assign bus.e       = e_q;
  assign bus.s1      = cur_q[1];
  assign bus.s0      = cur_q[0];
  assign bus.ramping = ramping_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// tb/tb_fan_speed_ctrl.sv - directed and random stimulus against a history-based reference model
module tb_fan_speed_ctrl;
  localparam int DB = 4;
  localparam int RC = 8;
  localparam int HN = 8192;
  localparam int K0 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fan_speed_ctrl_if bus();

  fan_speed_ctrl #(.DEBOUNCE_CYCLES(DB), .RAMP_CYCLES(RC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: raw samples per edge, debounced level per edge, then a plain speed controller.
  bit raw_h [3][HN];
  bit deb_h [3][HN];
  int last_flip [3];
  int k;
  int run, cur, tgt, tmr;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < HN; j++) begin
        raw_h[b][j] = 1'b0;
        deb_h[b][j] = 1'b0;
      end
      last_flip[b] = K0 - 1;
    end
    k = K0;
    run = 0; cur = 0; tgt = 1; tmr = 0;
  endtask

  task automatic model_edge();
    bit p [3];
    bit flip;
    if (k >= HN) begin
      $display("FAIL history_overflow: observed edge %0d required below %0d", k, HN);
      $fatal(1);
    end
    for (int b = 0; b < 3; b++) p[b] = deb_h[b][k-2] && !deb_h[b][k-3];
    raw_h[0][k] = bus.btn_pwr;
    raw_h[1][k] = bus.btn_up;
    raw_h[2][k] = bus.btn_down;
    // A level is accepted once the synchronized input (2 edges late) has disagreed for DB edges.
    for (int b = 0; b < 3; b++) begin
      flip = (k - last_flip[b] >= DB);
      for (int j = 0; j < DB; j++)
        if (raw_h[b][k-2-j] == deb_h[b][k-1]) flip = 1'b0;
      deb_h[b][k] = flip ? !deb_h[b][k-1] : deb_h[b][k-1];
      if (flip) last_flip[b] = k;
    end
    if (p[0]) begin
      run = !run;
      cur = 0;
      tmr = 0;
    end else begin
      if (p[1] && !p[2]) tgt = (tgt + 1 > 3) ? 3 : tgt + 1;
      if (p[2] && !p[1]) tgt = (tgt - 1 < 0) ? 0 : tgt - 1;
      if (run) begin
        if (cur > tgt) cur = tgt;
        if (cur < tgt) begin
          tmr++;
          if (tmr == RC) begin
            cur++;
            tmr = 0;
          end
        end else begin
          tmr = 0;
        end
      end
    end
    k++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check("e", 32'(bus.e), 32'(run));
    check("sel", 32'({bus.s1, bus.s0}), 32'(cur));
    check("ramping", 32'(bus.ramping), 32'(run != 0 && cur < tgt));
  endtask

  task automatic set_btn(input bit p, input bit u, input bit d);
    bus.btn_pwr  = p;
    bus.btn_up   = u;
    bus.btn_down = d;
  endtask

  task automatic press(input bit p, input bit u, input bit d);
    set_btn(p, u, d);
    repeat (6) tick();
    set_btn(0, 0, 0);
    repeat (12) tick();
  endtask

  initial begin
    int n;
    logic prev_r;
    set_btn(0, 0, 0);
    model_reset();
    #12;
    check("reset_e", 32'(bus.e), 0);
    check("reset_sel", 32'({bus.s1, bus.s0}), 0);
    check("reset_ramping", 32'(bus.ramping), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Power-on latency and first ramp step.
    bus.btn_pwr = 1'b1;
    n = 0;
    while (bus.e !== 1'b1 && n < 30) begin tick(); n++; end
    check("pwr_latency", 32'(n), 8);
    check("pwr_sel", 32'({bus.s1, bus.s0}), 0);
    n = 0;
    prev_r = 1'b0;
    while ({bus.s1, bus.s0} !== 2'b01 && n < 30) begin
      if (n == 2) bus.btn_pwr = 1'b0;
      prev_r = bus.ramping;
      tick();
      n++;
    end
    bus.btn_pwr = 1'b0;
    check("ramp_step", 32'(n), 8);
    check("ramping_before_step", 32'(prev_r), 1);
    check("ramping_after_step", 32'(bus.ramping), 0);
    repeat (10) tick();

    // Off, raise target to High, power on and ramp through all levels.
    press(1, 0, 0);
    check("off_e", 32'(bus.e), 0);
    press(0, 1, 0);
    press(0, 1, 0);
    check("off_sel", 32'({bus.s1, bus.s0}), 0);
    press(1, 0, 0);
    repeat (16) tick();
    check("ramp_high", 32'({bus.s1, bus.s0}), 3);
    check("ramp_high_done", 32'(bus.ramping), 0);

    // Instant slow-down, then saturate at Off-select with fan enabled.
    press(0, 0, 1);
    check("down_once", 32'({bus.s1, bus.s0}), 2);
    repeat (3) press(0, 0, 1);
    check("down_sat_sel", 32'({bus.s1, bus.s0}), 0);
    check("down_sat_e", 32'(bus.e), 1);

    // Short glitch and simultaneous up/down do nothing.
    set_btn(0, 1, 0);
    repeat (3) tick();
    set_btn(0, 0, 0);
    repeat (12) tick();
    check("glitch_sel", 32'({bus.s1, bus.s0}), 0);
    press(0, 1, 1);
    check("updown_sel", 32'({bus.s1, bus.s0}), 0);
    check("updown_ramping", 32'(bus.ramping), 0);

    // Reset in the middle of a ramp towards High.
    press(1, 0, 0);
    repeat (3) press(0, 1, 0);
    bus.btn_pwr = 1'b1;
    n = 0;
    while ({bus.s1, bus.s0} !== 2'b01 && n < 40) begin
      if (n == 6) bus.btn_pwr = 1'b0;
      tick();
      n++;
    end
    bus.btn_pwr = 1'b0;
    check("midramp_reached", 32'({bus.s1, bus.s0}), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_e", 32'(bus.e), 0);
    check("async_rst_sel", 32'({bus.s1, bus.s0}), 0);
    check("async_rst_ramping", 32'(bus.ramping), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    press(1, 0, 0);
    repeat (20) tick();
    check("post_rst_low", 32'({bus.s1, bus.s0}), 1);

    // Power and up together in RUN: off, target kept.
    press(0, 1, 0);
    repeat (8) tick();
    check("medium", 32'({bus.s1, bus.s0}), 2);
    press(1, 1, 0);
    check("pwr_up_off", 32'(bus.e), 0);
    press(1, 0, 0);
    repeat (20) tick();
    check("resume_target", 32'({bus.s1, bus.s0}), 2);
    check("resume_ramping", 32'(bus.ramping), 0);

    // Random button activity against the model.
    for (int it = 0; it < 300; it++) begin
      set_btn($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      repeat ($urandom_range(1, 10)) tick();
    end
    set_btn(0, 0, 0);
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
